// File: rtl/router_pkg.sv
// Shared constants and header helpers for the 1x3 router.
package router_pkg;

  localparam int DATA_W       = 8;
  localparam int FIFO_DEPTH   = 16;

  // Header byte layout: destination address in the low bits, payload length above it
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int MAX_PAYLOAD  = 63;

  // Wide enough for MAX_PAYLOAD bytes plus the trailing parity byte
  localparam int PKT_CNT_W    = 7;

  // Bytes still to follow a header: the payload length plus one parity byte
  function automatic logic [PKT_CNT_W-1:0] hdr_count(input logic [DATA_W-1:0] hdr);
    return PKT_CNT_W'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for one router FIFO: one write port, one registered read port.
// The array itself is never reset; only the read register is cleared.
module router_fifo_mem
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = DATA_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           flush,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [WIDTH:0] wr_word,
  input  logic           rd_en,
  input  logic [AW-1:0]  rd_addr,
  output logic [WIDTH:0] rd_word
);

  logic [WIDTH:0] mem [DEPTH];

  // Store an incoming word; contents are only meaningful between the pointers
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Registered read word; cleared so the visible data is zero after any reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_word <= '0;
    end else if (flush) begin
      rd_word <= '0;
    end else if (rd_en) begin
      rd_word <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/router_fifo.sv
// Per-destination packet FIFO: stores {header marker, byte} words and tracks
// packet framing on the read side so a stray payload byte is flagged.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 lfd_d;
  logic                 pop_d;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic [WIDTH:0]       rd_word;
  logic                 do_wr;
  logic                 do_rd;

  // The extra pointer MSB tells a full ring from an empty one
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A flush wins over any transfer requested in the same cycle
  assign do_wr = write_enb && !full  && !soft_reset;
  assign do_rd = read_enb  && !empty && !soft_reset;

  assign data_out  = rd_word[WIDTH-1:0];
  assign frame_err = pop_d && !rd_word[WIDTH] && (pkt_cnt == '0);

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .resetn  (resetn),
    .flush   (soft_reset),
    .wr_en   (do_wr),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_word ({lfd_d, data_in}),
    .rd_en   (do_rd),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_word (rd_word)
  );

  // Pointers, header-marker delay and the per-packet byte countdown
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lfd_d   <= 1'b0;
      pop_d   <= 1'b0;
      pkt_cnt <= '0;
    end else if (soft_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lfd_d   <= 1'b0;
      pop_d   <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      lfd_d <= lfd_state;
      pop_d <= do_rd;
      if (do_wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (pop_d) begin
        if (rd_word[WIDTH]) begin
          pkt_cnt <= hdr_count(rd_word[WIDTH-1:0]);
        end else if (pkt_cnt != '0) begin
          pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: a queue-based packet model predicts every
// pop, and a negedge monitor compares data, flags and framing errors.
module tb_router_fifo;

  localparam int DEPTH = 16;

  logic       clock;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;

  logic [8:0] model_q[$];
  logic [8:0] exp_q[$];
  int         remaining;
  logic [7:0] last_data;
  logic       lfd_prev;
  logic       mon_en;

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .frame_err  (frame_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    model_q.delete();
    exp_q.delete();
    remaining = 0;
    last_data = 8'h00;
    lfd_prev  = 1'b0;
  endtask

  // One clock of stimulus; the model advances right after the edge
  task automatic applyStimulus(input logic we, input logic re, input logic lfd,
                               input logic [7:0] din, input logic srst);
    int         pre_size;
    logic [8:0] w;
    logic       err;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = srst;
    @(posedge clock);
    if (srst) begin
      model_q.delete();
      remaining = 0;
      last_data = 8'h00;
      lfd_prev  = 1'b0;
    end else begin
      pre_size = model_q.size();
      if (re && pre_size > 0) begin
        w   = model_q.pop_front();
        err = 1'b0;
        if (w[8]) remaining = int'(w[7:2]) + 1;
        else if (remaining == 0) err = 1'b1;
        else remaining--;
        last_data = w[7:0];
        exp_q.push_back({err, w[7:0]});
      end
      if (we && pre_size < DEPTH) model_q.push_back({lfd_prev, din});
      lfd_prev = lfd;
    end
    #1;
  endtask

  // Monitor: flags every cycle, data and framing whenever a pop is due
  always @(negedge clock) begin
    logic [8:0] e;
    if (mon_en) begin
      checkOutput("empty", 32'(empty), 32'(model_q.size() == 0));
      checkOutput("full", 32'(full), 32'(model_q.size() == DEPTH));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pop_data", 32'(data_out), 32'(e[7:0]));
        checkOutput("pop_frame_err", 32'(frame_err), 32'(e[8]));
      end else begin
        checkOutput("hold_data", 32'(data_out), 32'(last_data));
        checkOutput("idle_frame_err", 32'(frame_err), 32'h0);
      end
    end
  end

  initial begin
    logic [7:0] pkt [5];
    mon_en     = 1'b0;
    resetn     = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    clearModel();
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    // Reset mid-traffic: flags and data clear immediately, nothing pops afterwards
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h30 + i), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    #2;
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst_empty", 32'(empty), 32'h1);
    checkOutput("async_rst_full", 32'(full), 32'h0);
    checkOutput("async_rst_data", 32'(data_out), 32'h0);
    clearModel();
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    mon_en = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Packet pass: header marked by lfd_state one cycle ahead of the byte
    pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h5E;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, pkt[i], 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Fill to full, drop an overflow write, then drain in order
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 254)), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Simultaneous read and write starting from full
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h80 + i), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hC1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hC2, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Bursts across several pointer wraps, then a flush with data held
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h11 * (i + 1)), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h77, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Framing error: a lone payload byte popped with no packet open
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h6B, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Random traffic with occasional headers and flushes
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
                    1'($urandom_range(0, 99) < 12), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 199) == 0));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    #1;
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
